// File: rtl/sseg_mux_n.sv
// N-digit multiplexed 7-segment driver with blanking, leading-zero suppression,
// PWM brightness and frame-aligned (tear-free) double-buffered loading.
module sseg_mux_n #(
  parameter int N_DIG    = 4,
  parameter int DWELL    = 50000,
  parameter int BRIGHT_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIG-1:0]    hex_in,
  input  logic [N_DIG-1:0]      dp_in,
  input  logic [N_DIG-1:0]      blank_in,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   bright,
  input  logic                  load,
  output logic                  update_done,
  output logic                  frame_tick,
  output logic [N_DIG-1:0]      an,
  output logic [7:0]            sseg
);

  localparam int DW_W  = $clog2(DWELL);
  localparam int IDX_W = $clog2(N_DIG);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIG - 1);

  logic [DW_W-1:0]     dwell_q, dwell_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wrapped_q, wrapped_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;
  logic [4*N_DIG-1:0]  shd_hex_q, shd_hex_d, act_hex_q, act_hex_d;
  logic [N_DIG-1:0]    shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
  logic [N_DIG-1:0]    shd_blank_q, shd_blank_d, act_blank_q, act_blank_d;
  logic                pend_q, pend_d;
  logic [N_DIG-1:0]    an_q, an_d;
  logic [7:0]          sseg_q, sseg_d;

  logic                dwell_wrap;
  logic [3:0]          cur_hex;
  logic                cur_dp, cur_blank, lit, zero_run;
  logic [N_DIG-1:0]    lz_mask;
  logic [7:0]          font;

  // wrapped_q holds off the very first frame_tick until one full scan has elapsed
  assign frame_tick  = wrapped_q && (dwell_q == '0) && (idx_q == '0);
  assign update_done = frame_tick && pend_q;
  assign an          = an_q;
  assign sseg        = sseg_q;

  always_comb begin
    dwell_wrap = (dwell_q == DWELL_LAST);
    dwell_d    = dwell_wrap ? '0 : dwell_q + 1'b1;
    idx_d      = idx_q;
    wrapped_d  = wrapped_q;
    if (dwell_wrap) begin
      if (idx_q == IDX_LAST) begin
        idx_d     = '0;
        wrapped_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    pwm_d = pwm_q + 1'b1;
  end

  // Frame copy uses the pre-load shadow; a coincident load re-arms pending
  always_comb begin
    shd_hex_d   = shd_hex_q;
    shd_dp_d    = shd_dp_q;
    shd_blank_d = shd_blank_q;
    act_hex_d   = act_hex_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    pend_d      = pend_q;
    if (update_done) begin
      act_hex_d   = shd_hex_q;
      act_dp_d    = shd_dp_q;
      act_blank_d = shd_blank_q;
      pend_d      = 1'b0;
    end
    if (load) begin
      shd_hex_d   = hex_in;
      shd_dp_d    = dp_in;
      shd_blank_d = blank_in;
      pend_d      = 1'b1;
    end
  end

  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = N_DIG - 1; k >= 0; k--) begin
      zero_run   = zero_run && (act_hex_q[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_run;
    end
    lz_mask[0] = 1'b0;

    cur_hex   = act_hex_q[{idx_q, 2'b00} +: 4];
    cur_dp    = act_dp_q[idx_q];
    cur_blank = act_blank_q[idx_q];

    case (cur_hex)
      4'h0: font = 8'hC0;  4'h1: font = 8'hF9;  4'h2: font = 8'hA4;  4'h3: font = 8'hB0;
      4'h4: font = 8'h99;  4'h5: font = 8'h92;  4'h6: font = 8'h82;  4'h7: font = 8'hF8;
      4'h8: font = 8'h80;  4'h9: font = 8'h90;  4'hA: font = 8'h88;  4'hB: font = 8'h83;
      4'hC: font = 8'hC6;  4'hD: font = 8'hA1;  4'hE: font = 8'h86;  default: font = 8'h8E;
    endcase

    lit    = !cur_blank && !(lz_en && lz_mask[idx_q]) && (pwm_q <= bright);
    an_d   = '1;
    sseg_d = 8'hFF;
    if (lit) begin
      an_d   = ~(N_DIG'(1) << idx_q);
      sseg_d = {~cur_dp, font[6:0]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_q     <= '0;
      idx_q       <= '0;
      wrapped_q   <= 1'b0;
      pwm_q       <= '0;
      shd_hex_q   <= '0;
      shd_dp_q    <= '0;
      shd_blank_q <= '0;
      act_hex_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      pend_q      <= 1'b0;
      an_q        <= '1;
      sseg_q      <= 8'hFF;
    end else begin
      dwell_q     <= dwell_d;
      idx_q       <= idx_d;
      wrapped_q   <= wrapped_d;
      pwm_q       <= pwm_d;
      shd_hex_q   <= shd_hex_d;
      shd_dp_q    <= shd_dp_d;
      shd_blank_q <= shd_blank_d;
      act_hex_q   <= act_hex_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      pend_q      <= pend_d;
      an_q        <= an_d;
      sseg_q      <= sseg_d;
    end
  end

endmodule

// File: tb/tb_sseg_mux_n.sv
// Self-checking bench for sseg_mux_n: directed scenarios plus random traffic
// compared against a cycle-count based reference model.
module tb_sseg_mux_n;
  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int BW    = 2;
  localparam int FRAME = N * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   hex_in = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    blank_in = '0;
  logic          lz_en = 1'b0;
  logic [BW-1:0] bright = 2'd3;
  logic          load = 1'b0;
  logic          update_done, frame_tick;
  logic [3:0]    an;
  logic [7:0]    sseg;

  int checks = 0;
  int failures = 0;

  // model: t = clock edges since reset release
  int          t;
  logic [15:0] m_shd_hex, m_act_hex;
  logic [3:0]  m_shd_dp, m_act_dp, m_shd_blank, m_act_blank;
  bit          m_pend;
  logic [7:0]  font_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  sseg_mux_n #(.N_DIG(N), .DWELL(DW), .BRIGHT_W(BW)) dut (
    .clk(clk), .reset(reset), .hex_in(hex_in), .dp_in(dp_in), .blank_in(blank_in),
    .lz_en(lz_en), .bright(bright), .load(load), .update_done(update_done),
    .frame_tick(frame_tick), .an(an), .sseg(sseg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0d)", tag, obs, exp_v, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_shd_hex = '0; m_act_hex = '0;
    m_shd_dp = '0; m_act_dp = '0;
    m_shd_blank = '0; m_act_blank = '0;
    m_pend = 1'b0;
  endtask

  // one clock: inputs must be stable on entry (called at posedge+1)
  task automatic cycle();
    bit         e_ft, lit;
    int         idx, pwm;
    logic [3:0] digit, e_an;
    logic [7:0] e_sseg, f;
    e_ft = (t >= FRAME) && (t % FRAME == 0);
    @(negedge clk);
    chk("frame_tick", frame_tick, e_ft);
    chk("update_done", update_done, e_ft && m_pend);
    idx   = (t / DW) % N;
    pwm   = t % (1 << BW);
    digit = 4'(m_act_hex >> (4 * idx));
    lit   = !m_act_blank[idx] && (pwm <= int'(bright))
            && !(lz_en && idx > 0 && (m_act_hex >> (4 * idx)) == 0);
    f      = font_tbl[digit];
    e_an   = lit ? ~(4'b0001 << idx) : 4'hF;
    e_sseg = lit ? {~m_act_dp[idx], f[6:0]} : 8'hFF;
    @(posedge clk);
    if (e_ft && m_pend) begin
      m_act_hex = m_shd_hex; m_act_dp = m_shd_dp; m_act_blank = m_shd_blank;
      m_pend = 1'b0;
    end
    if (load) begin
      m_shd_hex = hex_in; m_shd_dp = dp_in; m_shd_blank = blank_in;
      m_pend = 1'b1;
    end
    t++;
    #1;
    chk("an", an, e_an);
    chk("sseg", sseg, e_sseg);
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_sseg", sseg, 8'hFF);
    chk("rst_ft", frame_tick, 1'b0);
    chk("rst_ud", update_done, 1'b0);
    reset = 1'b1;
    model_reset();

    // scan order with all-zero active value
    run(3 * FRAME);

    // buffered load mid-frame with leading-zero suppression
    while (t % FRAME != 5) cycle();
    hex_in = 16'h00A1; lz_en = 1'b1; load = 1'b1;
    cycle();
    run(2 * FRAME);

    // brightness
    bright = 2'd1;
    run(2 * FRAME);
    bright = 2'd3;

    // pending load, then another load exactly on the frame boundary, with dp
    while (t % FRAME != 7) cycle();
    hex_in = 16'h1234; load = 1'b1;
    cycle();
    while (t % FRAME != 0) cycle();
    hex_in = 16'h5678; dp_in = 4'b0100; load = 1'b1;
    cycle();
    run(2 * FRAME + 3);

    // reset mid-frame while digit 2 is being scanned
    while ((t / DW) % N != 2) cycle();
    reset = 1'b0;
    #1;
    chk("mid_rst_an", an, 4'hF);
    chk("mid_rst_sseg", sseg, 8'hFF);
    chk("mid_rst_ft", frame_tick, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    lz_en = 1'b0; dp_in = '0;
    model_reset();
    run(FRAME + 2);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      hex_in   = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      lz_en    = 1'($urandom);
      bright   = BW'($urandom);
      load     = ($urandom_range(0, 5) == 0);
      if ((hex_in[15:8] != 0) && ($urandom_range(0, 2) == 0)) hex_in[15:8] = '0;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
